// File: rtl/npu_kernel_pkg.sv
// Shared constants and types for the kernel weight path between the loader
// and the convolution MAC array.
package npu_kernel_pkg;

  localparam int DEF_KERNEL_REG_ADDR_WIDTH = 5;
  localparam int DEF_WEIGHT_WIDTH          = 8;
  localparam int ELEM_COUNT_WIDTH          = 6;

  function automatic int max_elem_count(input int addr_width);
    return 2 ** addr_width;
  endfunction

  localparam int MAX_ELEM_COUNT = max_elem_count(DEF_KERNEL_REG_ADDR_WIDTH);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;

endpackage

// File: rtl/kernel_reg_file.sv
// One kernel weight bank: synchronous write port plus a registered read port
// whose output register doubles as the streamed weight register.
module kernel_reg_file
  import npu_kernel_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_KERNEL_REG_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_WEIGHT_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset so it can map onto a RAM/regfile macro;
  // only the read register below is reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/kernel_weight_bank.sv
// Ping-pong kernel weight store: loader fills one bank while the other is
// streamed in address order to the MAC array over valid/ready.
module kernel_weight_bank
  import npu_kernel_pkg::*;
#(
  parameter int KERNEL_REG_ADDR_WIDTH = DEF_KERNEL_REG_ADDR_WIDTH,
  parameter int WEIGHT_WIDTH          = DEF_WEIGHT_WIDTH
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_wr_en,
  input  logic [KERNEL_REG_ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [WEIGHT_WIDTH-1:0]          i_wr_data,
  input  logic                             i_load_done,
  input  logic [ELEM_COUNT_WIDTH-1:0]      i_elem_count,
  input  logic                             i_rd_start,
  input  logic                             i_rd_ready,
  output logic [WEIGHT_WIDTH-1:0]          o_weight,
  output logic                             o_weight_valid,
  output logic                             o_weight_last,
  output logic                             o_bank_avail,
  output logic                             o_wr_free,
  output logic                             o_err
);

  localparam int AW = KERNEL_REG_ADDR_WIDTH;
  localparam int CW = ELEM_COUNT_WIDTH;
  localparam logic [CW-1:0] MAX_COUNT = CW'(max_elem_count(AW));

  logic [1:0]              full_q, full_d;
  logic [CW-1:0]           count_q [2];
  logic                    wr_bank_q, rd_bank_q;
  logic                    err_q;
  rd_state_e               state_q, state_d;
  logic [AW-1:0]           idx_q, idx_inc;
  logic                    last_q;

  logic                    wr_open, count_ok, wr_accept, close_bank, load_err;
  logic                    handshake, stream_end, stream_start;
  logic                    rd_en;
  logic [AW-1:0]           rd_addr;
  logic [WEIGHT_WIDTH-1:0] bank_rd_data [2];

  // NOTE: every signal written in always_comb gets a value on every path
  // (here unconditionally), otherwise a latch is inferred.
  always_comb begin
    wr_open      = !full_q[wr_bank_q];
    wr_accept    = i_wr_en && wr_open;
    count_ok     = (i_elem_count != '0) && (i_elem_count <= MAX_COUNT);
    close_bank   = i_load_done && wr_open && count_ok;
    load_err     = (i_wr_en && !wr_open) || (i_load_done && !close_bank);
    handshake    = (state_q == STREAM) && i_rd_ready;
    stream_end   = handshake && last_q;
    stream_start = (state_q == IDLE) && i_rd_start && full_q[rd_bank_q];
    idx_inc      = idx_q + AW'(1);
  end

  // Closing the write bank and retiring the read bank can coincide; they
  // always address different banks, so both updates are applied.
  always_comb begin
    full_d = full_q;
    if (close_bank) full_d[wr_bank_q] = 1'b1;
    if (stream_end) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      full_q     <= '0;
      count_q[0] <= '0;
      count_q[1] <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      full_q <= full_d;
      if (close_bank) begin
        count_q[wr_bank_q] <= i_elem_count;
        wr_bank_q          <= !wr_bank_q;
      end
      if (stream_end) rd_bank_q <= !rd_bank_q;
      if (load_err)   err_q     <= 1'b1;
    end
  end

  // Reader FSM: state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Reader FSM: next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (stream_start) state_d = STREAM;
      STREAM:  if (stream_end)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Index and last flag track the beat currently held in the read registers,
  // so last is registered alongside the weight and holds through stalls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx_q  <= '0;
      last_q <= 1'b0;
    end else if (stream_start) begin
      idx_q  <= '0;
      last_q <= (count_q[rd_bank_q] == CW'(1));
    end else if (handshake) begin
      if (last_q) begin
        last_q <= 1'b0;
      end else begin
        idx_q  <= idx_inc;
        last_q <= (CW'(idx_inc) == count_q[rd_bank_q] - CW'(1));
      end
    end
  end

  // Reader FSM: outputs and read-port control.
  always_comb begin
    o_weight_valid = (state_q == STREAM);
    o_weight_last  = last_q;
    o_bank_avail   = full_q[rd_bank_q] && (state_q == IDLE);
    o_wr_free      = !full_q[wr_bank_q];
    o_err          = err_q;
    rd_en          = stream_start || (handshake && !last_q);
    rd_addr        = stream_start ? '0 : idx_inc;
    o_weight       = bank_rd_data[rd_bank_q];
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    kernel_reg_file #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (WEIGHT_WIDTH)
    ) u_bank (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .wr_en   (wr_accept && (wr_bank_q == 1'(b))),
      .wr_addr (i_wr_addr),
      .wr_data (i_wr_data),
      .rd_en   (rd_en && (rd_bank_q == 1'(b))),
      .rd_addr (rd_addr),
      .rd_data (bank_rd_data[b])
    );
  end

endmodule

// File: tb/tb_kernel_weight_bank.sv
// Directed bench for kernel_weight_bank: a bank model pushes expected beats
// into a scoreboard when a bank closes; streamed beats are popped and compared.
module tb_kernel_weight_bank;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_wr_en = 1'b0;
  logic [4:0] i_wr_addr = '0;
  logic [7:0] i_wr_data = '0;
  logic       i_load_done = 1'b0;
  logic [5:0] i_elem_count = '0;
  logic       i_rd_start = 1'b0;
  logic       i_rd_ready = 1'b0;
  logic [7:0] o_weight;
  logic       o_weight_valid, o_weight_last, o_bank_avail, o_wr_free, o_err;

  kernel_weight_bank dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_wr_en        (i_wr_en),
    .i_wr_addr      (i_wr_addr),
    .i_wr_data      (i_wr_data),
    .i_load_done    (i_load_done),
    .i_elem_count   (i_elem_count),
    .i_rd_start     (i_rd_start),
    .i_rd_ready     (i_rd_ready),
    .o_weight       (o_weight),
    .o_weight_valid (o_weight_valid),
    .o_weight_last  (o_weight_last),
    .o_bank_avail   (o_bank_avail),
    .o_wr_free      (o_wr_free),
    .o_err          (o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] w;
    logic       last;
  } beat_t;

  beat_t      sb[$];
  logic [7:0] m_mem [2][32];
  bit   [1:0] m_full;
  bit         m_wr, m_rd, m_err;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status();
    check("bank_avail", o_bank_avail, m_full[m_rd]);
    check("wr_free", o_wr_free, !m_full[m_wr]);
    check("err", o_err, m_err);
  endtask

  // Asserts reset wherever called, checks the asynchronous response, and
  // releases on the following falling edge.
  task automatic do_reset();
    i_rst = 1'b1;
    #1;
    check("rst_weight", o_weight, 0);
    check("rst_valid", o_weight_valid, 0);
    check("rst_last", o_weight_last, 0);
    check("rst_err", o_err, 0);
    check("rst_bank_avail", o_bank_avail, 0);
    check("rst_wr_free", o_wr_free, 1);
    @(negedge i_clk);
    i_rst = 1'b0;
    m_full = '0;
    m_wr = 1'b0;
    m_rd = 1'b0;
    m_err = 1'b0;
    sb.delete();
  endtask

  task automatic model_close(input int n);
    if (!m_full[m_wr] && n >= 1 && n <= 32) begin
      m_full[m_wr] = 1'b1;
      for (int i = 0; i < n; i++) sb.push_back('{w: m_mem[m_wr][i], last: (i == n - 1)});
      m_wr = !m_wr;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic write_w(input int a, input logic [7:0] d);
    i_wr_en = 1'b1;
    i_wr_addr = 5'(a);
    i_wr_data = d;
    if (!m_full[m_wr]) m_mem[m_wr][a] = d;
    else m_err = 1'b1;
    @(negedge i_clk);
    i_wr_en = 1'b0;
  endtask

  task automatic load_done(input int n);
    i_load_done = 1'b1;
    i_elem_count = 6'(n);
    model_close(n);
    @(negedge i_clk);
    i_load_done = 1'b0;
  endtask

  // Streams one bank. toggle: ready pattern 1,0,0 repeating. inject_n > 0
  // closes the write bank with that count on the final handshake. abort_at > 0
  // resets mid-cycle while beat abort_at is presented.
  task automatic stream(input int n, input bit toggle, input int inject_n,
                        input bit chk_free, input int abort_at);
    int hs, cyc;
    bit aborted;
    beat_t fr;
    hs = 0;
    cyc = 0;
    aborted = 1'b0;
    i_rd_start = 1'b1;
    @(negedge i_clk);
    i_rd_start = 1'b0;
    while (hs < n && cyc < 400) begin
      if (abort_at > 0 && hs == abort_at) begin
        i_rd_ready = 1'b0;
        #2;
        do_reset();
        aborted = 1'b1;
        break;
      end
      i_rd_ready = toggle ? (cyc % 3 == 0) : 1'b1;
      check("valid", o_weight_valid, 1);
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() == 0) break;
      fr = sb[0];
      check("weight", o_weight, fr.w);
      check("last", o_weight_last, fr.last);
      if (chk_free) check("wr_free_stream", o_wr_free, 1);
      if (i_rd_ready) begin
        if (fr.last && inject_n > 0) begin
          i_load_done = 1'b1;
          i_elem_count = 6'(inject_n);
          model_close(inject_n);
        end
        void'(sb.pop_front());
        hs++;
      end
      @(negedge i_clk);
      i_rd_ready = 1'b0;
      i_load_done = 1'b0;
      cyc++;
    end
    if (!aborted) begin
      check("handshakes", hs, n);
      m_full[m_rd] = 1'b0;
      m_rd = !m_rd;
      check("valid_after", o_weight_valid, 0);
      check_status();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    do_reset();
    check_status();

    // Basic 9-weight kernel; address 20 is stored but lies beyond N.
    for (int i = 0; i < 9; i++) write_w(i, 8'h11 + 8'(i));
    write_w(20, 8'hEE);
    load_done(9);
    check_status();
    stream(9, 1'b0, 0, 1'b1, 0);

    // Both banks full, dropped extra write, then in-order streaming with a
    // stalling consumer on the 25-weight kernel.
    for (int i = 0; i < 9; i++) write_w(i, 8'h30 + 8'(i));
    load_done(9);
    for (int i = 0; i < 25; i++) write_w(i, 8'h40 + 8'(i));
    load_done(25);
    check_status();
    write_w(3, 8'hFF);
    check_status();
    stream(9, 1'b0, 0, 1'b0, 0);
    stream(25, 1'b1, 0, 1'b0, 0);

    // Illegal element counts leave the bank open and flag an error.
    do_reset();
    load_done(0);
    check_status();
    do_reset();
    load_done(33);
    check_status();
    i_rd_start = 1'b1;
    @(negedge i_clk);
    i_rd_start = 1'b0;
    check("start_ignored", o_weight_valid, 0);

    // Final handshake of bank0 coincides with closing bank1.
    do_reset();
    for (int i = 0; i < 3; i++) write_w(i, 8'h51 + 8'(i));
    load_done(3);
    for (int i = 0; i < 5; i++) write_w(i, 8'hA0 + 8'(i));
    stream(3, 1'b0, 5, 1'b0, 0);
    check("overlap_avail", o_bank_avail, 1);
    check("overlap_wr_free", o_wr_free, 1);
    stream(5, 1'b0, 0, 1'b0, 0);

    // Reset during beat 4 aborts the stream and discards the loaded bank.
    do_reset();
    for (int i = 0; i < 9; i++) write_w(i, 8'h61 + 8'(i));
    load_done(9);
    stream(9, 1'b0, 0, 1'b0, 4);
    i_rd_start = 1'b1;
    @(negedge i_clk);
    i_rd_start = 1'b0;
    check("post_rst_start", o_weight_valid, 0);
    @(negedge i_clk);
    check("post_rst_idle", o_weight_valid, 0);
    check_status();
    write_w(0, 8'h77);
    write_w(1, 8'h78);
    load_done(2);
    stream(2, 1'b0, 0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
